// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and constants for the systolic array sequencer.
// Holds the sequencer state encoding, the PE operand/accumulator widths,
// and the drain length helper used to size the post-feed wait.
package systolic_pkg;

    localparam int OP_W  = 8;
    localparam int ACC_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_READ  = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    // Cycles after the last operand read until PE[ROWS-1][COLS-1] has
    // absorbed it: buffer read latency plus row and column skew.
    function automatic int drain_cycles(input int rd_lat, input int rows, input int cols);
        return rd_lat + rows + cols - 2;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Command, operand-read and result-handshake bundle of the sequencer.
// master: layer scheduler / array side (drives start, k_len, abort, res_ready).
// slave:  the sequencer itself (drives status, flush, reads and result select).
interface systolic_seq_ctrl_if #(
    parameter int ROWS = 4,
    parameter int KW   = 8
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic          start;
    logic [KW-1:0] k_len;
    logic          abort;
    logic          busy;
    logic          done;
    logic          pe_flush;
    logic          op_rd_en;
    logic [KW-1:0] op_rd_addr;
    logic          feed_valid;
    logic [RW-1:0] res_row;
    logic          res_valid;
    logic          res_ready;

    modport master (
        output start, k_len, abort, res_ready,
        input  busy, done, pe_flush, op_rd_en, op_rd_addr, feed_valid, res_row, res_valid
    );

    modport slave (
        input  start, k_len, abort, res_ready,
        output busy, done, pe_flush, op_rd_en, op_rd_addr, feed_valid, res_row, res_valid
    );
endinterface

// File: rtl/systolic_seq_ctrl_valid_delay_line.sv
// Delays the operand read strobe by the buffer read latency so that
// feed_valid lines up with the data leaving the operand buffers.
// Ports: clk, clr (synchronous clear), d (strobe in), q (delayed strobe).
module valid_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (clr) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];
endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an output-stationary ROWS x COLS PE array: accepts one
// tile command of depth k_len, clears the accumulators, streams K operand
// reads, waits for the skewed wavefront to drain, then hands out result
// rows over a valid/ready port.
// Ports: clk, rst (sync, active-high), bus (slave side of systolic_seq_ctrl_if).
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | waiting for start
// FLUSH    | one cycle of pe_flush to clear accumulators
// FEED     | K operand reads, addresses 0..K-1
// DRAIN    | read latency + skew propagation, no reads
// READ     | result rows 0..ROWS-1 handed out on valid/ready
// DONE     | one-cycle done pulse, then IDLE
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int KW     = 8,
    parameter int RD_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    systolic_seq_ctrl_if.slave bus
);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DRAIN = drain_cycles(RD_LAT, ROWS, COLS);
    localparam int DW    = $clog2(RD_LAT + ROWS + COLS);
    localparam int SW    = (KW > DW) ? KW : DW;

    localparam logic [SW-1:0] DRAIN_LAST = SW'(DRAIN - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    seq_state_t    state;
    logic [KW-1:0] k_q;
    logic [SW-1:0] step;
    logic          busy_q, done_q, flush_q, rd_en_q, rv_q;
    logic [KW-1:0] rd_addr_q;
    logic [RW-1:0] row_q;

    logic [KW-1:0] k_last;
    logic [SW-1:0] step_inc;
    logic          abort_act;
    logic          fv;

    // Terminal compare on K-1 so that K = 2^KW-1 never needs a KW+1 bit count.
    assign k_last    = k_q - 1'b1;
    assign step_inc  = step + 1'b1;
    assign abort_act = bus.abort && (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            k_q       <= '0;
            step      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            flush_q   <= 1'b1;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            row_q     <= '0;
            rv_q      <= 1'b0;
        end else if (abort_act) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            flush_q <= 1'b1;
            rd_en_q <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.k_len != '0) begin
                            k_q     <= bus.k_len;
                            state   <= ST_FLUSH;
                            busy_q  <= 1'b1;
                            flush_q <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    state     <= ST_FEED;
                    step      <= '0;
                    rd_addr_q <= '0;
                    rd_en_q   <= 1'b1;
                end
                ST_FEED: begin
                    if (step == SW'(k_last)) begin
                        state   <= ST_DRAIN;
                        rd_en_q <= 1'b0;
                        step    <= DRAIN_LAST;
                    end else begin
                        step      <= step_inc;
                        rd_addr_q <= step_inc[KW-1:0];
                    end
                end
                ST_DRAIN: begin
                    if (step == '0) begin
                        state <= ST_READ;
                        row_q <= '0;
                        rv_q  <= 1'b1;
                    end else begin
                        step <= step - 1'b1;
                    end
                end
                ST_READ: begin
                    if (bus.res_ready) begin
                        if (row_q == ROW_LAST) begin
                            state  <= ST_DONE;
                            rv_q   <= 1'b0;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    rv_q   <= 1'b0;
                end
            endcase
        end
    end

    valid_delay_line #(.DEPTH(RD_LAT)) u_feed_valid (
        .clk (clk),
        .clr (rst || abort_act),
        .d   (rd_en_q),
        .q   (fv)
    );

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pe_flush   = flush_q;
    assign bus.op_rd_en   = rd_en_q;
    assign bus.op_rd_addr = rd_addr_q;
    assign bus.feed_valid = fv;
    assign bus.res_row    = row_q;
    assign bus.res_valid  = rv_q;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
module tb_systolic_seq_ctrl;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int KW     = 8;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_seq_ctrl_if #(.ROWS(ROWS), .KW(KW)) bus ();

    systolic_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .KW(KW), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       start;
        logic [7:0] k;
        logic       abort;
        logic       ready;
        logic       busy;
        logic       done;
        logic       flush;
        logic       en;
        logic [7:0] addr;
        logic       fv;
        logic [1:0] row;
        logic       rv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic [7:0] k, input logic ab, input logic rdy,
                                input logic bsy, input logic dn, input logic fl, input logic en,
                                input logic [7:0] ad, input logic fv, input logic [1:0] rw, input logic rv);
        vec_t v;
        v.start = st; v.k = k; v.abort = ab; v.ready = rdy;
        v.busy = bsy; v.done = dn; v.flush = fl; v.en = en;
        v.addr = ad; v.fv = fv; v.row = rw; v.rv = rv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // addr is only meaningful while reading, row only while res_valid
    task automatic chk_outs(input string tag, input vec_t v);
        chk({tag, " busy"},  32'(bus.busy),       32'(v.busy));
        chk({tag, " done"},  32'(bus.done),       32'(v.done));
        chk({tag, " flush"}, 32'(bus.pe_flush),   32'(v.flush));
        chk({tag, " rd_en"}, 32'(bus.op_rd_en),   32'(v.en));
        chk({tag, " fv"},    32'(bus.feed_valid), 32'(v.fv));
        chk({tag, " rv"},    32'(bus.res_valid),  32'(v.rv));
        if (v.en) chk({tag, " addr"}, 32'(bus.op_rd_addr), 32'(v.addr));
        if (v.rv) chk({tag, " row"},  32'(bus.res_row),    32'(v.row));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- array model: operand buffers, skew, PE grid ----------------
    int A [ROWS][256];
    int B [256][COLS];
    int exp_m [ROWS][COLS];
    int acc [ROWS][COLS];
    int ar  [ROWS][COLS];
    int br  [ROWS][COLS];
    int ska [ROWS][ROWS];
    int skb [COLS][COLS];
    int da  [ROWS];
    int db  [COLS];
    logic chk_en = 1'b0;

    task automatic load_cmd(input int kk);
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < kk; k++) A[i][k] = int'($urandom_range(0, 255)) - 128;
        for (int k = 0; k < kk; k++)
            for (int j = 0; j < COLS; j++) B[k][j] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                exp_m[i][j] = 0;
                for (int k = 0; k < kk; k++) exp_m[i][j] += A[i][k] * B[k][j];
            end
    endtask

    // One model step per cycle, using the DUT outputs of that cycle; it
    // represents the array's update on the edge that ends the cycle.
    task automatic model_step();
        int inj_a [ROWS];
        int inj_b [COLS];
        int west  [ROWS];
        int north [COLS];
        int nar   [ROWS][COLS];
        int nbr   [ROWS][COLS];
        int a_in, b_in, ad, r;
        ad = int'(bus.op_rd_addr);
        if (chk_en && !rst && !bus.abort && bus.res_valid && bus.res_ready) begin
            r = int'(bus.res_row);
            for (int j = 0; j < COLS; j++)
                chk($sformatf("acc[%0d][%0d]", r, j), acc[r][j], exp_m[r][j]);
        end
        for (int i = 0; i < ROWS; i++) begin
            inj_a[i] = bus.feed_valid ? da[i] : 0;
            da[i] = A[i][ad];
            if (i == 0) west[i] = inj_a[i];
            else        west[i] = ska[i][i-1];
            for (int s = ROWS - 1; s > 0; s--) ska[i][s] = ska[i][s-1];
            ska[i][0] = inj_a[i];
        end
        for (int j = 0; j < COLS; j++) begin
            inj_b[j] = bus.feed_valid ? db[j] : 0;
            db[j] = B[ad][j];
            if (j == 0) north[j] = inj_b[j];
            else        north[j] = skb[j][j-1];
            for (int s = COLS - 1; s > 0; s--) skb[j][s] = skb[j][s-1];
            skb[j][0] = inj_b[j];
        end
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                if (j == 0) a_in = west[i];  else a_in = ar[i][j-1];
                if (i == 0) b_in = north[j]; else b_in = br[i-1][j];
                nar[i][j] = a_in;
                nbr[i][j] = b_in;
                if (bus.pe_flush) acc[i][j] = 0;
                else              acc[i][j] += a_in * b_in;
            end
        ar = nar;
        br = nbr;
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic start_cmd(input int kk);
        bus.start = 1'b1;
        bus.k_len = 8'(kk);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_until_done(input int limit, output int n);
        n = 0;
        while (!bus.done && n < limit) begin
            tick();
            n++;
        end
        if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
    endtask

    initial begin
        int n, cnt, last;
        rst = 1'b1;
        bus.start = 1'b0; bus.k_len = '0; bus.abort = 1'b0; bus.res_ready = 1'b1;
        repeat (2) tick();
        chk("rst busy",  32'(bus.busy), 0);
        chk("rst done",  32'(bus.done), 0);
        chk("rst flush", 32'(bus.pe_flush), 1);
        chk("rst rd_en", 32'(bus.op_rd_en), 0);
        chk("rst fv",    32'(bus.feed_valid), 0);
        chk("rst rv",    32'(bus.res_valid), 0);
        chk("rst addr",  32'(bus.op_rd_addr), 0);
        chk("rst row",   32'(bus.res_row), 0);
        rst = 1'b0;
        tick();
        chk("post-rst flush", 32'(bus.pe_flush), 0);

        // ---- nominal table, K=3 ----
        load_cmd(3);
        chk_en = 1'b1;
        vecs.push_back(mk(1, 3, 0, 1,  1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 0, 0, 1, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0));
        for (int r = 0; r < 4; r++)
            vecs.push_back(mk(0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 2'(r), 1));
        vecs.push_back(mk(0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            bus.start = vecs[i].start; bus.k_len = vecs[i].k;
            bus.abort = vecs[i].abort; bus.res_ready = vecs[i].ready;
            tick();
            chk_outs($sformatf("nom[%0d]", i), vecs[i]);
        end

        // ---- backpressure, K=1: hold row 1 for 3 cycles ----
        load_cmd(1);
        start_cmd(1);
        n = 0;
        while (!(bus.res_valid && bus.res_row == 2'd1) && n < 40) begin tick(); n++; end
        chk("bp row1 at", n, 10);
        bus.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); n++;
            chk("bp hold row", 32'(bus.res_row), 1);
            chk("bp hold rv",  32'(bus.res_valid), 1);
        end
        bus.res_ready = 1'b1;
        while (!bus.done && n < 60) begin tick(); n++; end
        chk("bp done at", n, 16);
        tick();

        // ---- zero depth ----
        bus.start = 1'b1; bus.k_len = 8'd0;
        tick();
        chk("zk done",  32'(bus.done), 1);
        chk("zk busy",  32'(bus.busy), 0);
        chk("zk flush", 32'(bus.pe_flush), 0);
        chk("zk rd_en", 32'(bus.op_rd_en), 0);
        bus.start = 1'b0;
        tick();
        chk("zk done2", 32'(bus.done), 0);
        chk("zk busy2", 32'(bus.busy), 0);
        chk("zk flush2", 32'(bus.pe_flush), 0);

        // ---- abort in IDLE is ignored ----
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("idle abort flush", 32'(bus.pe_flush), 0);

        // ---- abort during FEED at addr 1 ----
        load_cmd(5);
        start_cmd(5);
        n = 0;
        while (!(bus.op_rd_en && bus.op_rd_addr == 8'd1) && n < 20) begin tick(); n++; end
        chk("ab addr1 at", n, 2);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("ab busy",  32'(bus.busy), 0);
        chk("ab flush", 32'(bus.pe_flush), 1);
        chk("ab rd_en", 32'(bus.op_rd_en), 0);
        chk("ab fv",    32'(bus.feed_valid), 0);
        chk("ab done",  32'(bus.done), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ab after done",  32'(bus.done), 0);
            chk("ab after flush", 32'(bus.pe_flush), 0);
            chk("ab after busy",  32'(bus.busy), 0);
        end
        load_cmd(2);
        start_cmd(2);
        run_until_done(60, n);
        chk("ab next done at", n, 14);
        tick();

        // ---- reset while res_row=2 (start also high: reset wins) ----
        load_cmd(1);
        start_cmd(1);
        n = 0;
        while (!(bus.res_valid && bus.res_row == 2'd2) && n < 40) begin tick(); n++; end
        chk("rr row2 at", n, 11);
        rst = 1'b1; bus.start = 1'b1; bus.k_len = 8'd2;
        tick();
        chk("rr busy",  32'(bus.busy), 0);
        chk("rr done",  32'(bus.done), 0);
        chk("rr flush", 32'(bus.pe_flush), 1);
        chk("rr rd_en", 32'(bus.op_rd_en), 0);
        chk("rr fv",    32'(bus.feed_valid), 0);
        chk("rr rv",    32'(bus.res_valid), 0);
        chk("rr addr",  32'(bus.op_rd_addr), 0);
        chk("rr row",   32'(bus.res_row), 0);
        rst = 1'b0; bus.start = 1'b0;
        tick();
        chk("rr idle busy",  32'(bus.busy), 0);
        chk("rr idle flush", 32'(bus.pe_flush), 0);

        // ---- K=255 ----
        load_cmd(255);
        start_cmd(255);
        n = 0; cnt = 0; last = 0;
        while (!bus.done && n < 400) begin
            tick(); n++;
            if (bus.op_rd_en) begin
                chk("k255 addr", 32'(bus.op_rd_addr), cnt);
                last = int'(bus.op_rd_addr);
                cnt++;
            end
        end
        chk("k255 reads", cnt, 255);
        chk("k255 last addr", last, 254);
        chk("k255 done at", n, 267);
        tick();

        // ---- back-to-back with start held ----
        load_cmd(2);
        bus.start = 1'b1; bus.k_len = 8'd2;
        tick();
        run_until_done(60, n);
        chk("b2b first done at", n, 14);
        tick();
        chk("b2b gap flush", 32'(bus.pe_flush), 0);
        chk("b2b gap busy",  32'(bus.busy), 0);
        tick();
        chk("b2b flush", 32'(bus.pe_flush), 1);
        chk("b2b busy",  32'(bus.busy), 1);
        bus.start = 1'b0;
        run_until_done(60, n);
        chk("b2b second done at", n, 14);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
